sample_fetch_fsm: RTL and testbench

- Consumer stage directly downstream of the slow-to-fast strobe synchronizer. It runs entirely in the fast `outclk` domain.
- Each synchronized sample strobe causes one 16-bit audio sample to be delivered.
- Samples are unpacked from 32-bit words, two per word, read over an Avalon-MM-style read master (flash/SDRAM).
- Supports forward/reverse playback, pause and restart, with address wrap between configurable bounds.

---
 rtl/sample_fetch_fsm_if.sv | 26 ++
 rtl/sample_fetch_fsm.sv | 163 ++++++++++++++++
 tb/tb_sample_fetch_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_fetch_fsm_if.sv
// Avalon-MM-style read master bus between the sample fetch FSM and flash/SDRAM.
interface sample_fetch_fsm_if #(
  parameter int unsigned ADDR_W = 23
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

// File: rtl/sample_fetch_fsm.sv
// Sample fetch FSM: turns synchronized sample strobes into 16-bit audio samples
// unpacked two-per-word from 32-bit memory reads, with forward/reverse
// playback, pause, restart and address wrap between START_ADDR and END_ADDR.
// Optional macro SAMPLE_MISS_CNT_EN enables the saturating dropped-strobe counter.
module sample_fetch_fsm #(
  parameter int unsigned          ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]    START_ADDR = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]    END_ADDR   = ADDR_W'(32'h0007_FFFF)
) (
  input  logic                outclk,
  input  logic                reset_n,
  input  logic                sample_stb,
  input  logic                enable,
  input  logic                direction,
  input  logic                restart,
  sample_fetch_fsm_if.master  mem,
  output logic [15:0]         audio_data,
  output logic                audio_valid,
  output logic                busy,
  output logic [15:0]         miss_count
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    EMIT      = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_q;
  logic [WORD_W-1:0]   word_q;
  logic                buf_valid;
  logic                half;
  logic                dir_q;
  logic                restart_pend;

  logic                accept_c;
  logic                restart_eff_c;
  logic                sel_hi_c;
  logic [SAMPLE_W-1:0] sample_c;
  logic [ADDR_W-1:0]   step_addr_c;

  assign mem.mem_address = addr_q;
  assign mem.mem_read    = read_q;

  // Strobe qualification and restart that is pending or arriving this cycle
  assign accept_c      = sample_stb & enable;
  assign restart_eff_c = restart | restart_pend;

  // Half selection: forward emits low half first, reverse emits high half first
  assign sel_hi_c = dir_q ^ half;
  assign sample_c = sel_hi_c ? word_q[WORD_W-1:SAMPLE_W] : word_q[SAMPLE_W-1:0];

  // Next word address in the direction the current word was fetched with
  always_comb begin
    step_addr_c = addr_q;
    if (!dir_q) begin
      step_addr_c = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
    end else begin
      step_addr_c = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
    end
  end

  // Fetch/emit state machine with registered outputs
  always_ff @(posedge outclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_q       <= START_ADDR;
      read_q       <= 1'b0;
      word_q       <= '0;
      buf_valid    <= 1'b0;
      half         <= 1'b0;
      dir_q        <= 1'b0;
      restart_pend <= 1'b0;
      audio_data   <= '0;
      audio_valid  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      if (restart) begin
        restart_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (restart_eff_c) begin
            addr_q       <= direction ? END_ADDR : START_ADDR;
            buf_valid    <= 1'b0;
            half         <= 1'b0;
            restart_pend <= 1'b0;
          end else if (accept_c) begin
            busy <= 1'b1;
            if (buf_valid) begin
              state <= EMIT;
            end else begin
              state  <= REQ;
              read_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!mem.mem_waitrequest) begin
            read_q <= 1'b0;
            dir_q  <= direction;
            state  <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (mem.mem_readdatavalid) begin
            word_q    <= mem.mem_readdata;
            buf_valid <= 1'b1;
            half      <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          audio_data  <= sample_c;
          audio_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
          if (!half) begin
            half <= 1'b1;
          end else begin
            half      <= 1'b0;
            buf_valid <= 1'b0;
            addr_q    <= step_addr_c;
          end
        end
        default: begin
          state  <= IDLE;
          read_q <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAMPLE_MISS_CNT_EN
  logic        miss_c;
  logic [15:0] miss_q;

  // A play-mode strobe is missed when busy or when a restart takes priority
  assign miss_c = accept_c & ((state != IDLE) | restart_eff_c);

  // Saturating dropped-strobe counter, cleared only by reset
  always_ff @(posedge outclk or negedge reset_n) begin
    if (!reset_n) begin
      miss_q <= '0;
    end else if (miss_c && (miss_q != 16'hFFFF)) begin
      miss_q <= miss_q + 16'd1;
    end
  end

  assign miss_count = miss_q;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_fetch_fsm.sv
// Directed bench for sample_fetch_fsm: playback vector table plus stall/drop,
// pause, restart-mid-fetch and reset-mid-read sequences.
module tb_sample_fetch_fsm;

  localparam int unsigned ADDR_W  = 23;
  localparam logic [22:0] START_A = 23'h000000;
  localparam logic [22:0] END_A   = 23'h07FFFF;
`ifdef SAMPLE_MISS_CNT_EN
  localparam int MISS_INC = 1;
`else
  localparam int MISS_INC = 0;
`endif

  logic        outclk = 1'b0;
  logic        reset_n;
  logic        sample_stb;
  logic        enable;
  logic        direction;
  logic        restart;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        busy;
  logic [15:0] miss_count;

  int checks = 0;
  int fails  = 0;

  sample_fetch_fsm_if #(.ADDR_W(ADDR_W)) mem_if ();

  sample_fetch_fsm #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_A),
    .END_ADDR  (END_A)
  ) dut (
    .outclk     (outclk),
    .reset_n    (reset_n),
    .sample_stb (sample_stb),
    .enable     (enable),
    .direction  (direction),
    .restart    (restart),
    .mem        (mem_if),
    .audio_data (audio_data),
    .audio_valid(audio_valid),
    .busy       (busy),
    .miss_count (miss_count)
  );

  always #5 outclk = ~outclk;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == START_A) return 32'hAAAA5555;
    if (a == END_A)   return 32'h12345678;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: waitrequest for stall_left request cycles, data 2 cycles after acceptance
  int          stall_left = 0;
  int          lat_cnt    = 0;
  logic [22:0] acc_addr   = '0;
  initial begin
    mem_if.mem_waitrequest   = 1'b0;
    mem_if.mem_readdatavalid = 1'b0;
    mem_if.mem_readdata      = '0;
    forever begin
      @(negedge outclk);
      mem_if.mem_readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_if.mem_readdatavalid = 1'b1;
          mem_if.mem_readdata      = mem_word(acc_addr);
        end
      end
      if (mem_if.mem_read && stall_left > 0) begin
        mem_if.mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mem_if.mem_waitrequest = 1'b0;
      end
      if (mem_if.mem_read && !mem_if.mem_waitrequest) begin
        lat_cnt  = 2;
        acc_addr = mem_if.mem_address;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse a strobe and wait (bounded) for audio_valid; lat counts cycles after the strobe cycle
  task automatic strobe_and_wait(output logic [15:0] data, output int lat, output bit got);
    sample_stb = 1'b1;
    @(negedge outclk);
    sample_stb = 1'b0;
    got  = 1'b0;
    data = '0;
    lat  = 1;
    for (int i = 0; i < 60; i++) begin
      if (audio_valid) begin
        got  = 1'b1;
        data = audio_data;
        break;
      end
      @(negedge outclk);
      lat++;
    end
  endtask

  task automatic do_restart(input logic dir, input string name);
    direction = dir;
    restart   = 1'b1;
    @(negedge outclk);
    restart = 1'b0;
    check({name, "_rst_addr"}, 32'(mem_if.mem_address), 32'(dir ? END_A : START_A));
    @(negedge outclk);
  endtask

  typedef struct {
    bit          do_rst;
    bit          rst_dir;
    bit          play_dir;
    int          stall;
    logic [15:0] exp_data;
    int          exp_lat;
    logic [22:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [15:0] d;
    int          lat;
    bit          got;
    int          nvalid;
    int          miss0;
    bit          seen_read;
    bit          seen_valid;
    bit          seen_busy;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 0, 16'h5555, 5,  START_A};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 0, 16'hAAAA, 2,  23'h000001};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 0, 16'h1234, 5,  END_A};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 0, 16'h5678, 2,  END_A - 23'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 0, 16'hAAAA, 5,  START_A};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 0, 16'h5555, 2,  END_A};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 0, 16'h5678, 5,  END_A};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 0, 16'h1234, 2,  START_A};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 5, 16'h5555, 10, START_A};

    reset_n    = 1'b0;
    sample_stb = 1'b0;
    enable     = 1'b1;
    direction  = 1'b0;
    restart    = 1'b0;
    repeat (3) @(negedge outclk);
    check("reset_addr",  32'(mem_if.mem_address), 32'(START_A));
    check("reset_read",  32'(mem_if.mem_read), 32'd0);
    check("reset_data",  32'(audio_data), 32'd0);
    check("reset_valid", 32'(audio_valid), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_miss",  32'(miss_count), 32'd0);
    reset_n = 1'b1;
    @(negedge outclk);

    // Playback vector table
    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      if (vecs[v].do_rst) do_restart(vecs[v].rst_dir, nm);
      direction  = vecs[v].play_dir;
      stall_left = vecs[v].stall;
      strobe_and_wait(d, lat, got);
      check({nm, "_valid"}, 32'(got), 32'd1);
      check({nm, "_data"},  32'(d), 32'(vecs[v].exp_data));
      check({nm, "_lat"},   32'(lat), 32'(vecs[v].exp_lat));
      check({nm, "_addr"},  32'(mem_if.mem_address), 32'(vecs[v].exp_addr));
      @(negedge outclk);
    end

    // Stall and drop: second strobe lands in REQ
    do_restart(1'b0, "drop");
    miss0      = int'(miss_count);
    direction  = 1'b0;
    stall_left = 5;
    sample_stb = 1'b1;
    @(negedge outclk);
    sample_stb = 1'b0;
    nvalid = 0;
    @(negedge outclk);
    sample_stb = 1'b1;
    @(negedge outclk);
    sample_stb = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (audio_valid) nvalid++;
      @(negedge outclk);
    end
    check("drop_nvalid", 32'(nvalid), 32'd1);
    check("drop_miss", 32'(miss_count), 32'(miss0 + MISS_INC));

    // Restart takes priority over a same-cycle strobe in IDLE
    direction  = 1'b0;
    restart    = 1'b1;
    sample_stb = 1'b1;
    @(negedge outclk);
    restart    = 1'b0;
    sample_stb = 1'b0;
    seen_busy  = 1'b0;
    seen_read  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_busy |= busy;
      seen_read |= mem_if.mem_read;
      @(negedge outclk);
    end
    check("prio_busy", 32'(seen_busy), 32'd0);
    check("prio_read", 32'(seen_read), 32'd0);
    check("prio_miss", 32'(miss_count), 32'(miss0 + 2 * MISS_INC));

    // Pause: strobes ignored and not counted
    miss0      = int'(miss_count);
    enable     = 1'b0;
    seen_read  = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_stb = 1'b1;
      @(negedge outclk);
      sample_stb = 1'b0;
      seen_read  |= mem_if.mem_read;
      seen_valid |= audio_valid;
      @(negedge outclk);
      seen_read  |= mem_if.mem_read;
      seen_valid |= audio_valid;
    end
    check("pause_read",  32'(seen_read), 32'd0);
    check("pause_valid", 32'(seen_valid), 32'd0);
    check("pause_miss",  32'(miss_count), 32'(miss0));
    enable = 1'b1;

    // Restart during WAIT_DATA: in-flight sample still emitted, then rewind
    do_restart(1'b0, "rmid");
    strobe_and_wait(d, lat, got);
    @(negedge outclk);
    strobe_and_wait(d, lat, got);
    check("rmid_pre_addr", 32'(mem_if.mem_address), 32'd1);
    @(negedge outclk);
    sample_stb = 1'b1;
    @(negedge outclk);
    sample_stb = 1'b0;
    @(negedge outclk);
    restart = 1'b1;
    @(negedge outclk);
    restart = 1'b0;
    nvalid  = 0;
    d       = '0;
    for (int i = 0; i < 15; i++) begin
      if (audio_valid) begin
        nvalid++;
        d = audio_data;
      end
      @(negedge outclk);
    end
    check("rmid_nvalid", 32'(nvalid), 32'd1);
    check("rmid_data", 32'(d), 32'h0001);
    check("rmid_addr", 32'(mem_if.mem_address), 32'(START_A));
    strobe_and_wait(d, lat, got);
    check("rmid_refetch_data", 32'(d), 32'h5555);
    check("rmid_refetch_lat", 32'(lat), 32'd5);
    @(negedge outclk);
    strobe_and_wait(d, lat, got);
    check("rmid_buf_data", 32'(d), 32'hAAAA);
    @(negedge outclk);

    // Async reset while stalled in REQ
    stall_left = 5;
    sample_stb = 1'b1;
    @(negedge outclk);
    sample_stb = 1'b0;
    @(negedge outclk);
    check("rreq_pre_read", 32'(mem_if.mem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rreq_read",  32'(mem_if.mem_read), 32'd0);
    check("rreq_busy",  32'(busy), 32'd0);
    check("rreq_data",  32'(audio_data), 32'd0);
    check("rreq_valid", 32'(audio_valid), 32'd0);
    check("rreq_addr",  32'(mem_if.mem_address), 32'(START_A));
    check("rreq_miss",  32'(miss_count), 32'd0);
    @(negedge outclk);
    stall_left = 0;
    lat_cnt    = 0;
    reset_n    = 1'b1;
    @(negedge outclk);

    // Async reset in WAIT_DATA; the late readdatavalid must be ignored
    sample_stb = 1'b1;
    @(negedge outclk);
    sample_stb = 1'b0;
    @(negedge outclk);
    reset_n = 1'b0;
    @(negedge outclk);
    reset_n    = 1'b1;
    seen_valid = 1'b0;
    seen_busy  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_valid |= audio_valid;
      seen_busy  |= busy;
      @(negedge outclk);
    end
    check("late_valid", 32'(seen_valid), 32'd0);
    check("late_busy",  32'(seen_busy), 32'd0);
    strobe_and_wait(d, lat, got);
    check("late_fetch_data", 32'(d), 32'h5555);
    check("late_fetch_lat",  32'(lat), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
